fifo_wr_arbiter: RTL and testbench

- Write-side scheduler for the async FIFO: shares the single FIFO write port (wr/wdata) among NREQ requesters in the w_clk domain.
- Round-robin ownership with a bounded burst per owner.
- Honours the FIFO full flag so the FIFO overflow flag never asserts.
- Sits between the producer clients and the FIFO write interface; also exports write/stall statistics.

---
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler for the async FIFO (w_clk domain).
// Each owner may write up to BURST words back-to-back; a full FIFO stalls writes without releasing ownership.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int fw    = 8,
  parameter int BURST = 4,
  parameter int CW    = 16,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               w_clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*fw-1:0] req_data,
  input  logic               full,
  output logic [NREQ-1:0]    gnt,
  output logic               wr,
  output logic [fw-1:0]      wdata,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic [CW-1:0]      wr_count,
  output logic [CW-1:0]      stall_count
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   owner_nx;
  logic [BW-1:0]   burst_cnt, burst_nx;
  logic            own_req, grant_now, stall, handoff;
  logic [OW-1:0]   idx, rr_pick;
  logic            rr_found;

  assign own_req   = req[owner];
  assign grant_now = (state == BUSY) && own_req && !full;
  assign stall     = (state == BUSY) && own_req && full;
  assign handoff   = (grant_now && (burst_cnt == LAST)) || !own_req;

  // First requester after the current owner, excluding the owner itself.
  always_comb begin
    idx      = owner;
    rr_pick  = owner;
    rr_found = 1'b0;
    for (int i = 1; i < NREQ; i++) begin
      idx = OW'((int'(owner) + i) % NREQ);
      if (!rr_found && req[idx]) begin
        rr_pick  = idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    burst_nx = burst_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = BUSY;
          burst_nx = '0;
          if (rr_found) owner_nx = rr_pick;
        end
      end
      BUSY: begin
        if (handoff) begin
          burst_nx = '0;
          if (rr_found) owner_nx = rr_pick;
          else if (!own_req) state_nx = IDLE;
        end else if (grant_now) begin
          burst_nx = burst_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (grant_now) gnt[owner] = 1'b1;
    wr    = |gnt;
    busy  = (state == BUSY);
    wdata = busy ? req_data[int'(owner)*fw +: fw] : '0;
  end

  // Statistics wrap naturally at 2^CW.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (wr)    wr_count    <= wr_count + 1'b1;
      if (stall) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter: per-cycle vectors go through a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_fifo_wr_arbiter;

  logic        w_clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt;
  logic        wr;
  logic [7:0]  wdata;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] wr_count;
  logic [15:0] stall_count;

  typedef struct {
    logic        rst_before;
    logic [3:0]  req;
    logic        full;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        chk_cnt;
    logic [15:0] wc;
    logic [15:0] sc;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  logic [7:0]  words[4];
  int          vectors_applied = 0;
  int          miscompares = 0;

  fifo_wr_arbiter #(.NREQ(4), .fw(8), .BURST(4), .CW(16)) dut (
    .w_clk(w_clk), .rst(rst), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .wr(wr), .wdata(wdata), .owner(owner), .busy(busy),
    .wr_count(wr_count), .stall_count(stall_count)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic f, input logic [3:0] g,
                              input int o, input logic b, input logic c, input int wc, input int sc);
    vec_t v;
    v.rst_before = r;
    v.req = rq;
    v.full = f;
    v.gnt = g;
    v.owner = 2'(o);
    v.busy = b;
    v.chk_cnt = c;
    v.wc = 16'(wc);
    v.sc = 16'(sc);
    return v;
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic f, input logic [3:0] g,
                     input int o, input logic b, input logic c, input int wc, input int sc);
    vecs.push_back(mk(r, rq, f, g, o, b, c, wc, sc));
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge w_clk);
    #1;
    if (v.rst_before) begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end
    req  = v.req;
    full = v.full;
  endtask

  task automatic check_output(input string name, input vec_t e);
    logic [7:0] ew;
    logic       ewr;
    ew  = e.busy ? words[e.owner] : 8'h00;
    ewr = |e.gnt;
    vectors_applied++;
    if (gnt !== e.gnt || wr !== ewr || wdata !== ew || owner !== e.owner || busy !== e.busy ||
        (e.chk_cnt && (wr_count !== e.wc || stall_count !== e.sc))) begin
      miscompares++;
      $display("[TB] FAIL %s: got gnt=%b wr=%b wdata=%h owner=%0d busy=%b wc=%0d sc=%0d, want gnt=%b wr=%b wdata=%h owner=%0d busy=%b wc=%0d sc=%0d",
               name, gnt, wr, wdata, owner, busy, wr_count, stall_count,
               e.gnt, ewr, ew, e.owner, e.busy, e.wc, e.sc);
    end
  endtask

  initial begin
    words[0] = 8'hA1;
    words[1] = 8'hB2;
    words[2] = 8'hC3;
    words[3] = 8'hD4;
    req_data = {words[3], words[2], words[1], words[0]};
    rst  = 1'b1;
    req  = 4'b0000;
    full = 1'b0;

    // Single requester: ten gapless writes across a same-owner burst handoff.
    add(1, 4'b0001, 0, 4'b0000, 3, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 4'b0001, 0, 4'b0001, 0, 1, 1, k - 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 10, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 10, 0);

    // All four requesting: bursts of four rotate 0,1,2,3,0.
    add(1, 4'b1111, 0, 4'b0000, 3, 0, 1, 0, 0);
    for (int k = 0; k <= 16; k++) add(0, 4'b1111, 0, 4'(1 << ((k / 4) % 4)), (k / 4) % 4, 1, 1, k, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 17, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 17, 0);

    // Full for three cycles after owner 1 has written twice.
    add(1, 4'b0010, 0, 4'b0000, 3, 0, 1, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0, 0, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 1, 1, 2, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 1, 0, 0, 0);
    add(0, 4'b0010, 1, 4'b0000, 1, 1, 0, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 1, 2, 3);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 1, 3, 3);
    add(0, 4'b0000, 0, 4'b0000, 1, 1, 1, 4, 3);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 1, 4, 3);

    // Full while idle: the FSM still claims ownership and then stalls.
    add(0, 4'b0001, 1, 4'b0000, 1, 0, 1, 4, 3);
    add(0, 4'b0001, 1, 4'b0000, 0, 1, 1, 4, 3);
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 1, 4, 4);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 5, 4);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 5, 4);

    // Owner 2 drops after one write with 0 and 3 pending: handoff goes to 3, then 0.
    add(1, 4'b0100, 0, 4'b0000, 3, 0, 1, 0, 0);
    add(0, 4'b1101, 0, 4'b0100, 2, 1, 0, 0, 0);
    add(0, 4'b1001, 0, 4'b0000, 2, 1, 0, 0, 0);
    add(0, 4'b1001, 0, 4'b1000, 3, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 4'b0000, 3, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 1, 1, 3, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1, 3, 0);

    repeat (2) @(posedge w_clk);
    #1 rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      apply_stimulus(vecs[k]);
      sb.push_back(vecs[k]);
      @(negedge w_clk);
      check_output($sformatf("vec%0d", k), sb.pop_front());
    end

    // Asynchronous reset mid-burst, then requesters 1 and 3.
    @(posedge w_clk);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req = 4'b1111;
    full = 1'b0;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    check_output("pre_rst", mk(0, 4'b1111, 0, 4'b0001, 0, 1, 1, 2, 0));
    #1 rst = 1'b1;
    #1 check_output("async_rst", mk(0, 4'b1111, 0, 4'b0000, 3, 0, 1, 0, 0));
    @(posedge w_clk);
    #1;
    rst = 1'b0;
    req = 4'b1010;
    @(negedge w_clk);
    check_output("post_rst_idle", mk(0, 4'b1010, 0, 4'b0000, 3, 0, 1, 0, 0));
    @(negedge w_clk);
    check_output("post_rst_first", mk(0, 4'b1010, 0, 4'b0010, 1, 1, 1, 0, 0));
    @(negedge w_clk);
    check_output("post_rst_second", mk(0, 4'b1010, 0, 4'b0010, 1, 1, 1, 1, 0));
    req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
